hazard_unit_mc: RTL
===================

Name: hazard_unit_mc

Overview:
Parametrised hazard/forwarding controller for the 5-stage pipeline (F/D/E/M/W). It extends the single-cycle-memory hazard logic with three additions: a multi-cycle MUL/DIV unit tracked by an internal busy FSM, variable-latency data memory via a ready handshake with a watchdog, and a saturating stall-cycle counter for performance monitoring.

Parameters:
AW, 5, register address width
MD_LATENCY, 4, MUL/DIV latency in cycles (legal range 1..2^CW-1)
CW, 4, MUL/DIV countdown counter width
MEM_TIMEOUT, 64, consecutive memory-stall cycles before MemErr is raised
TW, 8, watchdog counter width (2^TW-1 >= MEM_TIMEOUT)
SW, 16, StallCount width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
BranchD  in  1  branch in D
MtoRFSelE, MtoRFSelM  in  1  load in E / M
RFWEE, RFWEM, RFWEW  in  1  register write enable in E/M/W
rsD, rtD, rsE, rtE  in  AW  source register addresses
RFAE, RFAM, RFAW  in  AW  destination register addresses in E/M/W
MDStartE  in  1  MUL/DIV issued in E
MDReadD  in  1  D instruction reads HI/LO or starts MUL/DIV
MemReqM  in  1  M stage is accessing data memory
MemReadyM  in  1  memory completes the M access this cycle
StallF, StallD, StallE, StallM  out  1  hold stage register
FlushE, FlushW  out  1  insert bubble into E / W
ForwardAD, ForwardBD  out  1  D-stage compare operand from M
ForwardAE, ForwardBE  out  2  E operand select: 00 = RF, 01 = W, 10 = M
MDBusy  out  1  MUL/DIV unit busy
MemErr  out  1  sticky watchdog error
StallCount  out  SW  saturating count of stall cycles

Behaviour:
- Reset: on a clk edge with rst_n=0, the following are cleared.
  - MD FSM goes to IDLE; MD counter = 0.
  - Watchdog = 0, MemErr = 0, StallCount = 0.
  - While rst_n=0, all combinational outputs are forced to 0.
- Register 0 never matches any hazard or forwarding comparison.
- Forwarding (combinational):
  - ForwardAD = rsD!=0 & rsD==RFAM & RFWEM. ForwardBD uses rtD in the same way.
  - ForwardAE = 10 if rsE!=0 & RFWEM & rsE==RFAM; else 01 if rsE!=0 & RFWEW & rsE==RFAW; else 00. M has priority over W.
  - ForwardBE is the same, using rtE.
- LWStall = MtoRFSelE & RFAE!=0 & (RFAE==rsD | RFAE==rtD).
- BRStall = BranchD & [ (RFWEE & RFAE!=0 & (RFAE==rsD | RFAE==rtD)) | (MtoRFSelM & RFAM!=0 & (RFAM==rsD | RFAM==rtD)) ].
- MD FSM, states IDLE and BUSY:
  - IDLE -> BUSY when MDStartE & !StallE; counter loads MD_LATENCY-1.
  - In BUSY the counter decrements every cycle, independent of stalls. BUSY -> IDLE on the edge where counter==0.
  - MDBusy = (state==BUSY). With MD_LATENCY=1, BUSY lasts exactly 1 cycle.
  - MDStall = MDReadD & (MDBusy | MDStartE).
- MemStall = MemReqM & !MemReadyM. MemStall has priority over the decode stall:
  - If MemStall: StallF = StallD = StallE = StallM = 1, FlushW = 1, FlushE = 0.
  - Else if (LWStall | BRStall | MDStall): StallF = StallD = 1, FlushE = 1, all others 0.
  - Else: all stall/flush outputs 0.
- MDStartE held during MemStall is accepted only on the first cycle StallE=0, exactly once.
- Watchdog:
  - Increments each MemStall cycle; clears on any cycle without MemStall.
  - When it reaches MEM_TIMEOUT, MemErr is set and stays 1 until reset.
  - The watchdog saturates at MEM_TIMEOUT. Stalls continue while MemStall persists.
- StallCount increments on every cycle with StallF=1 and saturates at 2^SW-1 (no wrap).

Test Plan:
- Forwarding: RFWEM=1, RFAM=5, RFWEW=1, RFAW=5, rsE=5 -> ForwardAE=10. Set RFWEM=0 -> 01. Set rsE=0 with all matches -> 00.
- Load-use: MtoRFSelE=1, RFAE=7, rtD=7 -> StallF=StallD=FlushE=1, StallE=0 for 1 cycle; StallCount 0 -> 1.
- MUL/DIV with MD_LATENCY=4: MDStartE pulse at cycle 0 -> MDBusy=1 on cycles 1-4 and 0 on cycle 5. MDReadD held high -> StallD=1 on cycles 0-4, released on cycle 5.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles with a simultaneous load-use hazard -> StallF/D/E/M=1, FlushW=1, FlushE=0 for 3 cycles. Then MemReadyM=1 -> FlushE=1 (decode stall resumes).
- Watchdog with MEM_TIMEOUT=64: MemStall held 64 cycles -> MemErr=1 from the 64th edge. Stall cleared -> MemErr stays 1. Drive rst_n=0 for 1 edge -> MemErr=0 and StallCount=0.
- Saturation with SW=4: 20 consecutive stall cycles -> StallCount=15.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
//   Hazard / forwarding controller for a 5-stage F/D/E/M/W pipeline with a
//   multi-cycle MUL/DIV unit, variable-latency data memory and a saturating
//   stall-cycle counter.
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   BranchD               : branch resolving in D
//   MtoRFSelE/M           : load instruction in E / M
//   RFWEE/M/W             : register write enable in E / M / W
//   rsD, rtD, rsE, rtE    : source register addresses
//   RFAE/M/W              : destination register addresses in E / M / W
//   MDStartE, MDReadD     : MUL/DIV issue in E, HI/LO consumer in D
//   MemReqM, MemReadyM    : data-memory request / completion in M
//   StallF/D/E/M          : hold stage registers
//   FlushE, FlushW        : bubble into E / W
//   ForwardAD/BD          : D-stage compare operand taken from M
//   ForwardAE/BE          : E operand select (00 RF, 01 W, 10 M)
//   MDBusy                : MUL/DIV unit busy
//   MemErr                : sticky memory watchdog error
//   StallCount            : saturating count of StallF cycles
module hazard_unit_mc #(
    parameter int AW          = 5,
    parameter int MD_LATENCY  = 4,
    parameter int CW          = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int TW          = 8,
    parameter int SW          = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          BranchD,
    input  logic          MtoRFSelE,
    input  logic          MtoRFSelM,
    input  logic          RFWEE,
    input  logic          RFWEM,
    input  logic          RFWEW,
    input  logic [AW-1:0] rsD,
    input  logic [AW-1:0] rtD,
    input  logic [AW-1:0] rsE,
    input  logic [AW-1:0] rtE,
    input  logic [AW-1:0] RFAE,
    input  logic [AW-1:0] RFAM,
    input  logic [AW-1:0] RFAW,
    input  logic          MDStartE,
    input  logic          MDReadD,
    input  logic          MemReqM,
    input  logic          MemReadyM,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          StallM,
    output logic          FlushE,
    output logic          FlushW,
    output logic          ForwardAD,
    output logic          ForwardBD,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          MDBusy,
    output logic          MemErr,
    output logic [SW-1:0] StallCount
);

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    localparam logic [CW-1:0] MD_LOAD = CW'(MD_LATENCY - 1);
    localparam logic [TW-1:0] WD_MAX  = TW'(MEM_TIMEOUT);
    localparam logic [TW-1:0] WD_LAST = TW'(MEM_TIMEOUT - 1);

    md_state_t      md_state;
    logic [CW-1:0]  md_cnt;
    logic [TW-1:0]  wd_cnt;
    logic           mem_err;
    logic [SW-1:0]  stall_cnt;

    logic           lw_stall, br_stall, md_stall, mem_stall, dec_stall;
    logic           md_busy;

    // E-stage operand select; M is the younger producer so it wins over W.
    function automatic logic [1:0] fwd_e(
        input logic [AW-1:0] src,
        input logic          wem,
        input logic [AW-1:0] am,
        input logic          wew,
        input logic [AW-1:0] aw
    );
        if (src != '0 && wem && src == am)      return 2'b10;
        else if (src != '0 && wew && src == aw) return 2'b01;
        else                                    return 2'b00;
    endfunction

    assign md_busy   = (md_state == MD_BUSY);
    assign lw_stall  = MtoRFSelE && RFAE != '0 && (RFAE == rsD || RFAE == rtD);
    assign br_stall  = BranchD &&
                       ((RFWEE && RFAE != '0 && (RFAE == rsD || RFAE == rtD)) ||
                        (MtoRFSelM && RFAM != '0 && (RFAM == rsD || RFAM == rtD)));
    // The op issuing in E this cycle is already in flight for a D reader.
    assign md_stall  = MDReadD && (md_busy || MDStartE);
    assign mem_stall = MemReqM && !MemReadyM;
    assign dec_stall = lw_stall || br_stall || md_stall;

    // All combinational outputs are held low while reset is asserted.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        MDBusy    = 1'b0;
        if (rst_n) begin
            ForwardAD = rsD != '0 && rsD == RFAM && RFWEM;
            ForwardBD = rtD != '0 && rtD == RFAM && RFWEM;
            ForwardAE = fwd_e(rsE, RFWEM, RFAM, RFWEW, RFAW);
            ForwardBE = fwd_e(rtE, RFWEM, RFAM, RFWEW, RFAW);
            MDBusy    = md_busy;
            // A memory wait freezes the whole front of the pipe; the decode
            // bubble would otherwise be lost, so it is deferred until M moves.
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (dec_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            md_state  <= MD_IDLE;
            md_cnt    <= '0;
            wd_cnt    <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            // MUL/DIV countdown runs regardless of pipeline stalls.
            case (md_state)
                MD_IDLE: if (MDStartE && !StallE) begin
                    md_state <= MD_BUSY;
                    md_cnt   <= MD_LOAD;
                end
                MD_BUSY: begin
                    if (md_cnt == '0) md_state <= MD_IDLE;
                    else              md_cnt   <= md_cnt - 1'b1;
                end
                default: md_state <= MD_IDLE;
            endcase

            if (mem_stall) begin
                if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == WD_LAST || wd_cnt == WD_MAX) mem_err <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end

            if (StallF && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign MemErr     = mem_err;
    assign StallCount = stall_cnt;

endmodule
